// File: rtl/ga_mv_lsu_pkg.sv
// ga_mv_lsu_pkg: multivector layouts, LSU state/command types and even-subalgebra pack helpers.
// Used by ga_mv_lsu; GA_LSU_EVEN_PACK_EN selects the 256-bit even memory image.
package ga_mv_lsu_pkg;
  localparam int GA_MV_SIZE = 512;
  localparam int GA_EVEN_MV_SIZE = 256;
  localparam int GA_LSU_BEAT_W = 32;
  localparam int GA_LSU_BEATS = GA_MV_SIZE / GA_LSU_BEAT_W;
  typedef logic [15:0] ga_coef_t;
  // Blades ordered by grade, scalar at the MSB end; e123oi occupies the LSW.
  typedef struct packed {
    ga_coef_t scalar;
    ga_coef_t e1, e2, e3, eo, ei;
    ga_coef_t e12, e13, e1o, e1i, e23, e2o, e2i, e3o, e3i, eoi;
    ga_coef_t e123, e12o, e12i, e13o, e13i, e1oi, e23o, e23i, e2oi, e3oi;
    ga_coef_t e123o, e123i, e12oi, e13oi, e23oi;
    ga_coef_t e123oi;
  } ga_multivector_t;
  typedef struct packed {
    ga_coef_t scalar;
    ga_coef_t e12, e13, e1o, e1i, e23, e2o, e2i, e3o, e3i, eoi;
    ga_coef_t e123o, e123i, e12oi, e13oi, e23oi;
  } ga_even_multivector_t;
  typedef enum logic [2:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE, LSU_ERR} ga_lsu_state_e;
  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [4:0]  reg_addr;
  } ga_lsu_cmd_t;
  function automatic ga_even_multivector_t mv_to_even(input ga_multivector_t mv);
    return {mv[511:496], mv[415:256], mv[95:16]};
  endfunction
  function automatic ga_multivector_t even_to_mv(input ga_even_multivector_t ev);
    return {ev[255:240], 80'd0, ev[239:80], 160'd0, ev[79:0], 16'd0};
  endfunction
endpackage

// File: rtl/ga_mv_lsu.sv
// ga_mv_lsu: sequences one multivector load/store as single-outstanding word beats on the data bus.
// GA_LSU_EVEN_PACK_EN: memory image is the 256-bit even part (8 beats) instead of the full 512 bits.
module ga_mv_lsu
  import ga_mv_lsu_pkg::*;
#(
  parameter int BEAT_W = GA_LSU_BEAT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_store_i,
  input  logic [31:0]           cmd_addr_i,
  input  logic [4:0]            cmd_reg_i,
  input  ga_multivector_t       st_data_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [BEAT_W/8-1:0]   data_be_o,
  output logic [31:0]           data_addr_o,
  output logic [BEAT_W-1:0]     data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [BEAT_W-1:0]     data_rdata_i,
  input  logic                  data_err_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output ga_multivector_t       rf_wdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o
);
`ifdef GA_LSU_EVEN_PACK_EN
  localparam int IMG_W = GA_EVEN_MV_SIZE;
`else
  localparam int IMG_W = GA_MV_SIZE;
`endif
  localparam int NUM_BEATS = IMG_W / BEAT_W;
  localparam int CNT_W = $clog2(NUM_BEATS);
  localparam logic [2:0] S_IDLE = LSU_IDLE;
  localparam logic [2:0] S_REQ = LSU_REQ;
  localparam logic [2:0] S_WAIT = LSU_WAIT;
  localparam logic [2:0] S_DONE = LSU_DONE;
  localparam logic [2:0] S_ERR = LSU_ERR;
  logic [2:0] state, state_nxt;
  logic [CNT_W-1:0] k;
  logic [IMG_W-1:0] buffer, st_img;
  ga_lsu_cmd_t cmd;
  logic accept, beat_ok, last;
`ifdef GA_LSU_EVEN_PACK_EN
  assign st_img = mv_to_even(st_data_i);
  assign rf_wdata_o = even_to_mv(buffer);
`else
  assign st_img = st_data_i;
  assign rf_wdata_o = buffer;
`endif
  assign accept = state == S_IDLE && cmd_valid_i;
  assign beat_ok = state == S_WAIT && data_rvalid_i && !data_err_i;
  assign last = k == CNT_W'(NUM_BEATS - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid_i) state_nxt = cmd_addr_i[1:0] != 2'b00 ? S_ERR : S_REQ;
      S_REQ: if (data_gnt_i) state_nxt = S_WAIT;
      S_WAIT: if (data_rvalid_i) state_nxt = data_err_i ? S_ERR : (last ? S_DONE : S_REQ);
      default: state_nxt = S_IDLE;
    endcase
  end
  // A store keeps its image in the beat buffer; a load assembles into it beat by beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      k <= '0;
      buffer <= '0;
      cmd <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd <= '{store: cmd_store_i, addr: cmd_addr_i, reg_addr: cmd_reg_i};
        buffer <= st_img;
        k <= '0;
      end
      if (beat_ok && !cmd.store) buffer[32'(k)*BEAT_W +: BEAT_W] <= data_rdata_i;
      if (beat_ok && !last) k <= k + 1'b1;
    end
  end
  assign cmd_ready_o = state == S_IDLE;
  assign busy_o = state != S_IDLE;
  assign data_req_o = state == S_REQ;
  assign data_we_o = data_req_o && cmd.store;
  assign data_be_o = {(BEAT_W/8){data_req_o}};
  assign data_addr_o = cmd.addr + 32'(k) * 32'(BEAT_W/8);
  assign data_wdata_o = buffer[32'(k)*BEAT_W +: BEAT_W];
  assign done_o = state == S_DONE;
  assign rf_we_o = done_o && !cmd.store;
  assign rf_waddr_o = cmd.reg_addr;
  assign err_o = state == S_ERR;
endmodule

// File: tb/tb_ga_mv_lsu.sv
// tb_ga_mv_lsu: directed bench for ga_mv_lsu with a negedge-driven single-outstanding bus memory.
module tb_ga_mv_lsu;
  import ga_mv_lsu_pkg::*;
`ifdef GA_LSU_EVEN_PACK_EN
  localparam int NB = 8;
`else
  localparam int NB = 16;
`endif
  logic clk = 1'b0, rst_ni = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_store_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [4:0] cmd_reg_i = '0;
  ga_multivector_t st_data_i = '0, rf_wdata_o, mv;
  logic data_req_o, data_gnt_i = 1'b0, data_we_o;
  logic [3:0] data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
  logic data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic rf_we_o, done_o, err_o, busy_o;
  logic [4:0] rf_waddr_o;
  logic [79:0] outs;
  always #5 clk = ~clk;
  ga_mv_lsu dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_store_i(cmd_store_i), .cmd_addr_i(cmd_addr_i), .cmd_reg_i(cmd_reg_i), .st_data_i(st_data_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );
  assign outs = {cmd_ready_o, busy_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
                 rf_we_o, rf_waddr_o, done_o, err_o};
  localparam logic [79:0] RST_OUTS = {1'b1, 79'd0};
  logic [31:0] mem [0:8191];
  int tests = 0, fails = 0;
  int grants = 0, req_seen = 0, rf_we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int stall_beat = -1, stall_n = 0, stalled = 0, err_beat = -1;
  logic [31:0] beat_base = '0;
  logic [31:0] g_addr[$], s_addr[$], s_wdata[$];
  logic g_we[$], s_we[$];
  logic [3:0] s_be[$];
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Bus memory: grant decided at negedge for the coming edge, response one cycle after grant.
  initial begin
    logic pend, perr;
    logic [31:0] pdata;
    int k;
    pend = 1'b0; perr = 1'b0; pdata = '0;
    forever begin
      @(negedge clk);
      data_rvalid_i = pend;
      data_rdata_i = pend ? pdata : '0;
      data_err_i = pend && perr;
      pend = 1'b0;
      data_gnt_i = 1'b0;
      if (rst_ni) begin
        if (data_req_o) begin
          req_seen++;
          k = int'((data_addr_o - beat_base) >> 2);
          if (k == stall_beat && stalled < stall_n) begin
            stalled++;
            s_addr.push_back(data_addr_o);
            s_wdata.push_back(data_wdata_o);
            s_we.push_back(data_we_o);
            s_be.push_back(data_be_o);
          end else begin
            data_gnt_i = 1'b1;
            pend = 1'b1;
            grants++;
            g_addr.push_back(data_addr_o);
            g_we.push_back(data_we_o);
            if (data_we_o) mem[data_addr_o[14:2]] = data_wdata_o;
            else pdata = mem[data_addr_o[14:2]];
            perr = k == err_beat;
          end
        end
        rf_we_cnt += int'(rf_we_o);
        done_cnt += int'(done_o);
        err_cnt += int'(err_o);
      end
    end
  end
  task automatic run(input logic st, input logic [31:0] addr, input logic [4:0] r,
                     input logic [511:0] d, output int n);
    @(negedge clk);
    beat_base = addr;
    cmd_valid_i = 1'b1; cmd_store_i = st; cmd_addr_i = addr; cmd_reg_i = r; st_data_i = d;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n = 1;
    while (!(done_o || err_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, g0, s0, rq0, we0, dn0, er0, allz;
    logic [511:0] exp_full;
    for (int j = 0; j < 8192; j++) mem[j] = 32'hA000_0000 + 32'(j - 1024);
    exp_full = '0;
    for (int i = 0; i < 16; i++) exp_full[32*i +: 32] = 32'hA000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    check("reset_outs", 512'(outs), 512'(RST_OUTS));
    check("reset_rf_wdata", rf_wdata_o, '0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_outs", 512'(outs), 512'(RST_OUTS));
    // 1: zero-wait load at 0x1000
    g0 = grants;
    run(1'b0, 32'h1000, 5'd5, '0, n);
    check("t1_done_cycle", 512'(n), 512'(2*NB + 1));
    check("t1_done", 512'(done_o), 512'd1);
    check("t1_rf_we", 512'(rf_we_o), 512'd1);
    check("t1_rf_waddr", 512'(rf_waddr_o), 512'd5);
`ifndef GA_LSU_EVEN_PACK_EN
    check("t1_rf_lsw", 512'(rf_wdata_o[31:0]), 512'(32'hA000_0000));
    check("t1_rf_full", rf_wdata_o, exp_full);
`endif
    @(negedge clk);
    check("t1_ready_next", 512'(cmd_ready_o), 512'd1);
    check("t1_rf_we_pulse", 512'(rf_we_o), 512'd0);
    check("t1_beats", 512'(grants - g0), 512'(NB));
    for (int i = 0; i < NB; i++) begin
      check($sformatf("t1_addr%0d", i), 512'(g_addr[g0+i]), 512'(32'h1000 + 32'(4*i)));
      check($sformatf("t1_we%0d", i), 512'(g_we[g0+i]), 512'd0);
    end
    // 2: store of 1 at 0x2000, beat 5 stalled 3 cycles
    g0 = grants; s0 = s_addr.size(); we0 = rf_we_cnt;
    stall_beat = 5; stall_n = 3; stalled = 0;
    run(1'b1, 32'h2000, 5'd9, 512'h1, n);
    check("t2_done_cycle", 512'(n), 512'(2*NB + 1 + 3));
    check("t2_done", 512'(done_o), 512'd1);
    check("t2_rf_we", 512'(rf_we_o), 512'd0);
    @(negedge clk);
    stall_beat = -1;
    check("t2_stall_cnt", 512'(s_addr.size() - s0), 512'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_stall_addr%0d", i), 512'(s_addr[s0+i]), 512'(32'h2014));
      check($sformatf("t2_stall_wdata%0d", i), 512'(s_wdata[s0+i]), 512'd0);
      check($sformatf("t2_stall_ctl%0d", i), 512'({s_we[s0+i], s_be[s0+i]}), 512'(5'h1F));
    end
    check("t2_beats", 512'(grants - g0), 512'(NB));
    check("t2_grant5_addr", 512'(g_addr[g0+5]), 512'(32'h2014));
`ifdef GA_LSU_EVEN_PACK_EN
    check("t2_word0", 512'(mem[12'h800]), 512'd0);
`else
    check("t2_word0", 512'(mem[12'h800]), 512'd1);
`endif
    allz = 1;
    for (int i = 1; i < NB; i++) if (mem[12'h800 + i] !== 32'd0) allz = 0;
    check("t2_words_zero", 512'(allz), 512'd1);
    check("t2_beyond_untouched", 512'(mem[12'h800 + NB]), 512'(32'hA000_0000 + 32'(1024 + NB)));
    check("t2_no_rf_we", 512'(rf_we_cnt - we0), 512'd0);
    // 3: misaligned load
    rq0 = req_seen; we0 = rf_we_cnt;
    run(1'b0, 32'h3002, 5'd1, '0, n);
    check("t3_err_cycle", 512'(n), 512'd1);
    check("t3_err", 512'(err_o), 512'd1);
    check("t3_rf_we", 512'(rf_we_o), 512'd0);
    @(negedge clk);
    check("t3_err_pulse", 512'(err_o), 512'd0);
    check("t3_ready_next", 512'(cmd_ready_o), 512'd1);
    check("t3_no_req", 512'(req_seen - rq0), 512'd0);
    check("t3_no_rf_we", 512'(rf_we_cnt - we0), 512'd0);
    // 4: bus error on beat 7
    g0 = grants; we0 = rf_we_cnt; dn0 = done_cnt; er0 = err_cnt;
    err_beat = 7;
    run(1'b0, 32'h1000, 5'd2, '0, n);
    check("t4_err_cycle", 512'(n), 512'd17);
    check("t4_err", 512'(err_o), 512'd1);
    check("t4_rf_we", 512'(rf_we_o), 512'd0);
    @(negedge clk);
    check("t4_ready_next", 512'(cmd_ready_o), 512'd1);
    repeat (4) @(negedge clk);
    err_beat = -1;
    check("t4_beats", 512'(grants - g0), 512'd8);
    check("t4_err_cnt", 512'(err_cnt - er0), 512'd1);
    check("t4_no_done", 512'(done_cnt - dn0), 512'd0);
    check("t4_no_rf_we", 512'(rf_we_cnt - we0), 512'd0);
    // 5: reset during beat 4, then a clean load
    we0 = rf_we_cnt; dn0 = done_cnt; er0 = err_cnt;
    @(negedge clk);
    beat_base = 32'h1000;
    cmd_valid_i = 1'b1; cmd_store_i = 1'b0; cmd_addr_i = 32'h1000; cmd_reg_i = 5'd3;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n = 0;
    while (!(data_req_o && data_addr_o == 32'h1010) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_beat4", 512'(n < 100), 512'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t5_async_outs", 512'(outs), 512'(RST_OUTS));
    check("t5_async_rf_wdata", rf_wdata_o, '0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_no_pulses", 512'({rf_we_cnt - we0, done_cnt - dn0, err_cnt - er0}), 512'd0);
    run(1'b0, 32'h1000, 5'd4, '0, n);
    check("t5_done_cycle", 512'(n), 512'(2*NB + 1));
    check("t5_rf_we", 512'(rf_we_o), 512'd1);
    check("t5_rf_waddr", 512'(rf_waddr_o), 512'd4);
`ifndef GA_LSU_EVEN_PACK_EN
    check("t5_rf_full", rf_wdata_o, exp_full);
`endif
    @(negedge clk);
`ifdef GA_LSU_EVEN_PACK_EN
    // 6: even-packed load at 0x4000
    g0 = grants;
    run(1'b0, 32'h4000, 5'd6, '0, n);
    mv = rf_wdata_o;
    check("t6_done_cycle", 512'(n), 512'd17);
    check("t6_rf_we", 512'(rf_we_o), 512'd1);
    check("t6_e1", 512'(mv.e1), 512'd0);
    check("t6_e123", 512'(mv.e123), 512'd0);
    check("t6_eo", 512'(mv.eo), 512'd0);
    check("t6_scalar", 512'(mv.scalar), 512'(mem[4096+7][31:16]));
    check("t6_e23oi", 512'(mv.e23oi), 512'(mem[4096][15:0]));
    @(negedge clk);
    check("t6_beats", 512'(grants - g0), 512'd8);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
